layer3_maxpool_stream: RTL and testbench
========================================

Name: layer3_maxpool_stream

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the layer-3 1x1 convolution.
- Consumes the convolution's packed, ReLU'd 16-channel pixel word, one pixel per in_valid beat, in raster order.
- Emits one pooled 16-channel pixel per 2x2 window.
- A half-width line buffer holds the horizontal maxima of each even row until the matching odd row arrives.

Parameters:
- bits, 16, width of one channel value.
- bits_shift, 4, log2 of per-channel lane pitch in the packed bus (lane i at [(i<<bits_shift)+bits-1 : i<<bits_shift]).
- channel_num, 16, channels per pixel.
- img_w, 8, input feature-map width in pixels; must be even, otherwise elaboration error.
- img_h, 8, input feature-map height in pixels; must be even, otherwise elaboration error.

Ports:
- clk_in, input, 1, sole clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- data_in, input, channel_num<<bits_shift, packed input pixel from the layer-3 conv.
- in_valid, input, 1, data_in carries a pixel this cycle.
- sof, input, 1, qualified by in_valid: this beat is pixel (row 0, col 0) of a new frame.
- data_out, output, channel_num<<bits_shift, packed pooled pixel.
- out_valid, output, 1, data_out valid this cycle (single-cycle pulse per pooled pixel).
- frame_done, output, 1, pulses together with the out_valid of the last pooled pixel of a frame.

Behaviour:
- Reset (async, rst=1): col=0, row=0, hold register=0, data_out=0, out_valid=0, frame_done=0. Line buffer is not reset; every entry is written in the even row before it is read.
- Only beats with in_valid=1 advance state. Idle cycles (in_valid=0) freeze all counters and registers and force out_valid=0. Arbitrary gaps are legal.
- Position counters:
  - col increments per beat and wraps img_w-1 -> 0.
  - On col wrap, row increments and wraps img_h-1 -> 0.
  - Counters wrap silently at frame end; the next frame starts at (0,0) even without sof.
- sof with in_valid: the beat is treated as (0,0) regardless of the counters.
  - Counters continue from (0,1); a partially received frame is discarded.
  - A sof arriving exactly at (0,0) is a no-op.
- Comparison: per channel, unsigned, bits wide, lanes independent. Ties take either operand (values are equal).
- Even col: hold register <= data_in.
- Odd col: hmax = lanewise max(hold, data_in).
  - Even row: linebuf[col>>1] <= hmax (img_w/2 entries × full bus width).
  - Odd row: data_out <= lanewise max(linebuf[col>>1], hmax), and out_valid <= 1 on the next edge.
- Latency: out_valid is asserted in the cycle after the in_valid beat at (odd row, odd col). Throughput is one pooled pixel per 4 input beats, and never more than one output per cycle.
- frame_done <= 1 in the same cycle as the out_valid for input position (img_h-1, img_w-1). Otherwise 0.
- data_out holds its last value while out_valid=0.
- Reset mid-frame: all counters return to (0,0), any pending output is dropped, and the next in_valid beat is pixel (0,0).

Optional Feature:
- Macro MAXPOOL_SIGNED_CMP_EN.
- Defined: lane comparisons are two's-complement signed, for use when the upstream ReLU is bypassed, e.g. 16'hFFFF (-1) < 16'h0001.
- Undefined (default): unsigned comparison, e.g. 16'hFFFF > 16'h0001.
- Datapath widths and timing are identical in both builds.

Test Plan:
- Bench uses img_w=4, img_h=4, channel_num=16.
- 1. Ramp: lane0 of pixel (r,c) = 4r+c, other lanes 0, continuous in_valid. Expected: 4 out_valid pulses with lane0 = 5, 7, 13, 15. frame_done accompanies the 15. Each out_valid occurs one cycle after beats 6, 8, 14, 16.
- 2. Same frame with in_valid toggled 1-0-1-0. Expected: identical outputs, each out_valid one cycle after its triggering beat, and no outputs during gaps.
- 3. Per-lane independence: lane k of pixel (0,0) = 100+k, all other values 1. Expected: first output lane k = 100+k, remaining outputs all lanes = 1.
- 4. Signedness: one window containing 16'hFFFF and 16'h0001 in lane 3, the rest 0. Expected: lane3 out = 16'hFFFF in the default build, 16'h0001 with MAXPOOL_SIGNED_CMP_EN.
- 5. sof restart: send 5 pixels, then a sof beat followed by a full ramp frame. Expected: exactly 4 outputs matching scenario 1 and no stale-window output.
- 6. Reset mid-frame: assert rst after 10 beats. Expected: out_valid/frame_done drop immediately and data_out=0. A full frame after release yields the scenario-1 results.

Source files
------------

// File: rtl/layer3_maxpool_stream.sv
// layer3_maxpool_stream: 2x2, stride-2 max-pooling stage behind the layer-3 1x1 conv.
// Accepts one packed 16-channel pixel per in_valid beat in raster order. It emits one
// pooled pixel for each 2x2 window, one cycle after the beat at (odd row, odd col).
// Optional build macro MAXPOOL_SIGNED_CMP_EN switches the lane compare to two's-complement
// signed. When the macro is undefined, the lane compare is unsigned.
module layer3_maxpool_stream #(
  parameter int bits        = 16,
  parameter int bits_shift  = 4,
  parameter int channel_num = 16,
  parameter int img_w       = 8,
  parameter int img_h       = 8
) (
  input  logic                                clk_in,
  input  logic                                rst,
  input  logic [(channel_num<<bits_shift)-1:0] data_in,
  input  logic                                in_valid,
  input  logic                                sof,
  output logic [(channel_num<<bits_shift)-1:0] data_out,
  output logic                                out_valid,
  output logic                                frame_done
);

  localparam int BW = channel_num << bits_shift;
  localparam int CW = (img_w > 1) ? $clog2(img_w) : 1;
  localparam int RW = (img_h > 1) ? $clog2(img_h) : 1;
  localparam int LD = img_w / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(img_w - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_h - 1);

  // Window geometry relies on both dimensions being even.
  if ((img_w % 2) != 0) begin : g_bad_w
    $error("layer3_maxpool_stream: img_w must be even");
  end
  if ((img_h % 2) != 0) begin : g_bad_h
    $error("layer3_maxpool_stream: img_h must be even");
  end

  // Lanewise max over the packed bus; lane pad bits (if any) are driven to zero.
  function automatic logic [BW-1:0] lane_max(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0]   r;
    logic [bits-1:0] la;
    logic [bits-1:0] lb;
    r = '0;
    for (int unsigned i = 0; i < channel_num; i++) begin
      la = a[(i << bits_shift) +: bits];
      lb = b[(i << bits_shift) +: bits];
`ifdef MAXPOOL_SIGNED_CMP_EN
      r[(i << bits_shift) +: bits] = ($signed(la) > $signed(lb)) ? la : lb;
`else
      r[(i << bits_shift) +: bits] = (la > lb) ? la : lb;
`endif
    end
    return r;
  endfunction

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [BW-1:0] hold_q, hold_d;
  logic [BW-1:0] dout_q, dout_d;
  logic          ov_q, ov_d;
  logic          fd_q, fd_d;

  logic [BW-1:0] linebuf_q [LD];
  logic [LW-1:0] lb_idx;
  logic [BW-1:0] lb_rd;
  logic          lb_we;
  logic [BW-1:0] hmax;

  // Effective position of the current beat: sof forces (0,0) regardless of the counters.
  always_comb begin
    col_cur = (in_valid && sof) ? '0 : col_q;
    row_cur = (in_valid && sof) ? '0 : row_q;
    lb_idx  = LW'(col_cur >> 1);
    lb_rd   = linebuf_q[lb_idx];
    hmax    = lane_max(hold_q, data_in);
  end

  // Next-state: advance position, capture even-col pixel, stash even-row maxima, pool odd rows.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    dout_d = dout_q;
    ov_d   = 1'b0;
    fd_d   = 1'b0;
    lb_we  = 1'b0;
    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
      if (!col_cur[0]) begin
        hold_d = data_in;
      end else if (!row_cur[0]) begin
        lb_we = 1'b1;
      end else begin
        dout_d = lane_max(lb_rd, hmax);
        ov_d   = 1'b1;
        fd_d   = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
      end
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      dout_q <= '0;
      ov_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
      ov_q   <= ov_d;
      fd_q   <= fd_d;
    end
  end

  // Line buffer holds even-row horizontal maxima; every entry is written before it is read.
  always_ff @(posedge clk_in) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= hmax;
    end
  end

  assign data_out   = dout_q;
  assign out_valid  = ov_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_layer3_maxpool_stream.sv
// Self-checking bench for layer3_maxpool_stream (4x4 frame, 16 x 16-bit lanes).
module tb_layer3_maxpool_stream;
  localparam int BW = 256;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          sof;
  logic [BW-1:0] data_in;
  logic [BW-1:0] data_out;
  logic          out_valid;
  logic          frame_done;

  always #5 clk_in = ~clk_in;

  layer3_maxpool_stream #(
    .bits(16), .bits_shift(4), .channel_num(16), .img_w(W), .img_h(H)
  ) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in), .in_valid(in_valid), .sof(sof),
    .data_out(data_out), .out_valid(out_valid), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: frame contents by position, expected outputs.
  logic [BW-1:0] mframe [NP];
  int            mr, mc;
  logic          exp_v, exp_fd;
  logic [BW-1:0] exp_d;
  logic [BW-1:0] fr [NP];
  logic [BW-1:0] cap [$];
  bit            capfd [$];
  int            capbeat [$];
  int            bn;

  function automatic int lane_val(input logic [15:0] x);
`ifdef MAXPOOL_SIGNED_CMP_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  function automatic logic [BW-1:0] pmax(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[k*16 +: 16] = (lane_val(a[k*16 +: 16]) >= lane_val(b[k*16 +: 16])) ? a[k*16 +: 16] : b[k*16 +: 16];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_pix();
    logic [BW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; exp_v = 1'b0; exp_fd = 1'b0; exp_d = '0;
  endtask

  // One clock cycle: drive inputs, update model, check outputs 1 time unit after the edge.
  task automatic step(input bit v, input bit s, input logic [BW-1:0] pix);
    in_valid = v; sof = s; data_in = pix;
    exp_v = 1'b0; exp_fd = 1'b0;
    if (v) begin
      bn++;
      if (s) begin mr = 0; mc = 0; end
      mframe[mr*W + mc] = pix;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        exp_v  = 1'b1;
        exp_fd = (mr == H-1) && (mc == W-1);
        exp_d  = pmax(pmax(mframe[(mr-1)*W + mc-1], mframe[(mr-1)*W + mc]),
                      pmax(mframe[mr*W + mc-1], pix));
      end
      mc++;
      if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
    end
    @(posedge clk_in); #1;
    check("out_valid", BW'(out_valid), BW'(exp_v));
    check("frame_done", BW'(frame_done), BW'(exp_fd));
    check("data_out", data_out, exp_d);
    if (out_valid === 1'b1) begin
      cap.push_back(data_out); capfd.push_back(frame_done); capbeat.push_back(bn);
    end
    in_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic start_capture();
    cap.delete(); capfd.delete(); capbeat.delete(); bn = 0;
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < NP; p++) fr[p] = BW'(p);
  endtask

  task automatic send_frame(input bit gaps, input bit use_sof);
    for (int p = 0; p < NP; p++) begin
      step(1'b1, use_sof && (p == 0), fr[p]);
      if (gaps) step(1'b0, 1'b0, rnd_pix());
    end
  endtask

  // Ramp frame results are fixed: lane0 = 5, 7, 13, 15 after beats 6, 8, 14, 16.
  task automatic verify_ramp(input string tag);
    int ev [4] = '{5, 7, 13, 15};
    int eb [4] = '{6, 8, 14, 16};
    check({tag, "_count"}, BW'(cap.size()), BW'(4));
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      check({tag, "_value"}, cap[i], BW'(ev[i]));
      check({tag, "_beat"}, BW'(capbeat[i]), BW'(eb[i]));
      check({tag, "_fdone"}, BW'(capfd[i]), BW'(i == 3));
    end
  endtask

  initial begin
    logic [BW-1:0] tmp;
    logic [BW-1:0] e0;
    logic [15:0]   s4;

    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; data_in = '0;
    model_reset(); bn = 0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_out_valid", BW'(out_valid), '0);
    check("reset_frame_done", BW'(frame_done), '0);
    check("reset_data_out", data_out, '0);
    @(negedge clk_in) rst = 1'b0;
    @(posedge clk_in); #1;

    // 1: continuous ramp
    fill_ramp(); start_capture();
    send_frame(1'b0, 1'b0);
    verify_ramp("s1");

    // 2: ramp with idle cycles between beats
    start_capture();
    send_frame(1'b1, 1'b0);
    verify_ramp("s2");

    // 3: per-lane independence
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 16; k++) fr[p][k*16 +: 16] = 16'd1;
    for (int k = 0; k < 16; k++) fr[0][k*16 +: 16] = 16'(100 + k);
    e0 = fr[0];
    tmp = fr[1];
    start_capture();
    send_frame(1'b0, 1'b0);
    check("s3_count", BW'(cap.size()), BW'(4));
    if (cap.size() == 4) begin
      check("s3_first", cap[0], e0);
      for (int i = 1; i < 4; i++) check("s3_rest", cap[i], tmp);
    end

    // 4: signedness of lane compare
    for (int p = 0; p < NP; p++) fr[p] = '0;
    fr[0][48 +: 16] = 16'hFFFF;
    fr[1][48 +: 16] = 16'h0001;
`ifdef MAXPOOL_SIGNED_CMP_EN
    s4 = 16'h0001;
`else
    s4 = 16'hFFFF;
`endif
    start_capture();
    send_frame(1'b0, 1'b0);
    check("s4_count", BW'(cap.size()), BW'(4));
    if (cap.size() > 0) begin
      tmp = cap[0];
      check("s4_lane3", BW'(tmp[48 +: 16]), BW'(s4));
      tmp[48 +: 16] = 16'h0000;
      check("s4_other_lanes", tmp, '0);
    end

    // 5: partial frame then sof restart
    start_capture();
    for (int p = 0; p < 5; p++) step(1'b1, 1'b0, rnd_pix());
    bn = 0;
    fill_ramp();
    send_frame(1'b0, 1'b1);
    verify_ramp("s5");

    // 6: reset in the middle of a frame
    start_capture();
    for (int p = 0; p < 10; p++) step(1'b1, 1'b0, fr[p]);
    rst = 1'b1;
    #2;
    check("s6_rst_out_valid", BW'(out_valid), '0);
    check("s6_rst_frame_done", BW'(frame_done), '0);
    check("s6_rst_data_out", data_out, '0);
    model_reset();
    @(negedge clk_in) rst = 1'b0;
    @(posedge clk_in); #1;
    start_capture();
    send_frame(1'b0, 1'b0);
    verify_ramp("s6");

    // 7: random data, random gaps, occasional sof
    for (int i = 0; i < 200; i++) begin
      bit v;
      bit s;
      v = ($urandom_range(0, 9) < 7);
      s = v && ($urandom_range(0, 19) == 0);
      step(v, s, rnd_pix());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
